// File: rtl/desloca_seq_if.sv
// Handshake and data bundle for the desloca_seq multi-cycle shift unit.
// The requester drives start/mode/amt/a; the shifter returns status, result and flags.
interface desloca_seq_if #(
   parameter int WIDTH = 8
) ();
   localparam int SHW = $clog2(WIDTH);

   logic             start;
   logic [1:0]       mode;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] a;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;
   logic             carry;
   logic             zero;

   modport master (
      output start, mode, amt, a,
      input  ready, busy, done, y, carry, zero
   );

   modport slave (
      input  start, mode, amt, a,
      output ready, busy, done, y, carry, zero
   );
endinterface

// File: rtl/desloca_seq.sv
// Multi-cycle shifter: SRL/SLL/SRA/ROR, one bit position per clock under a
// start/ready/done handshake, with carry-out and zero flags for the ALU.
module desloca_seq #(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input logic         clk,
   input logic         rst,
   desloca_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SRL, SLL, SRA, ROR} mode_t;

   localparam logic [SHW-1:0] ONE = SHW'(1);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [SHW-1:0]   count_q, count_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             carry_q, carry_d;

   // Returns {next_y, bit_shifted_out} for a single position.
   function automatic logic [WIDTH:0] step(input mode_t m, input logic [WIDTH-1:0] v);
      logic [WIDTH:0] r;
      case (m)
         SRL:     r = {1'b0, v[WIDTH-1:1], v[0]};
         SLL:     r = {v[WIDTH-2:0], 1'b0, v[WIDTH-1]};
         SRA:     r = {v[WIDTH-1], v[WIDTH-1:1], v[0]};
         ROR:     r = {v[0], v[WIDTH-1:1], v[0]};
         default: r = {v, 1'b0};
      endcase
      return r;
   endfunction

   // NOTE: every signal gets its hold value first so no path through the
   // case can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      y_d     = y_q;
      carry_d = carry_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               y_d     = bus.a;
               mode_d  = mode_t'(bus.mode);
               count_d = bus.amt;
               carry_d = 1'b0;
               state_d = (bus.amt == '0) ? DONE : SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            {y_d, carry_d} = step(mode_q, y_q);
            count_d        = count_q - ONE;
            state_d        = (count_q == ONE) ? DONE : SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= SRL;
         count_q <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         y_q     <= y_d;
         carry_q <= carry_d;
      end
   end

   assign bus.ready = (state_q == IDLE) || (state_q == DONE);
   assign bus.busy  = (state_q == SHIFT);
   assign bus.done  = (state_q == DONE);
   assign bus.y     = y_q;
   assign bus.carry = carry_q;
   assign bus.zero  = (y_q == '0);

endmodule

// File: tb/tb_desloca_seq.sv
// Self-checking bench for desloca_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_desloca_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [W-1:0] last_y;
   logic         last_c;

   always #5 clk = ~clk;

   desloca_seq_if #(.WIDTH(W)) bus ();

   desloca_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Whole-operation result computed directly from shift arithmetic.
   function automatic void model(input logic [1:0] m, input logic [W-1:0] va, input int amt,
                                 output logic [W-1:0] ey, output logic ec);
      case (m)
         2'd0: begin ey = va >> amt;            ec = (amt != 0) ? va[amt-1] : 1'b0; end
         2'd1: begin ey = va << amt;            ec = (amt != 0) ? va[W-amt] : 1'b0; end
         2'd2: begin ey = $signed(va) >>> amt;  ec = (amt != 0) ? va[amt-1] : 1'b0; end
         default: begin
            ey = (va >> amt) | (va << (W - amt));
            ec = (amt != 0) ? va[amt-1] : 1'b0;
         end
      endcase
   endfunction

   // Runs one operation. b2b=1 means the caller is already at the negedge
   // where done is visible, so the start is issued from DONE.
   task automatic op(input logic [1:0] m, input logic [W-1:0] va, input int amt,
                     input bit b2b, input string tag);
      logic [W-1:0] ey;
      logic         ec;
      int           lat;
      int           nbusy;
      if (!b2b) begin
         @(negedge clk);
         check({tag, "_idle_done"}, bus.done, 0);
         check({tag, "_idle_ready"}, bus.ready, 1);
         check({tag, "_hold_y"}, bus.y, last_y);
         check({tag, "_hold_c"}, bus.carry, last_c);
      end
      bus.start = 1'b1;
      bus.mode  = m;
      bus.a     = va;
      bus.amt   = 3'(amt);
      model(m, va, amt, ey, ec);
      @(negedge clk);
      lat   = 1;
      nbusy = 0;
      while (!bus.done && lat <= W + 2) begin
         if (bus.busy) nbusy++;
         bus.start = 1'($urandom);
         bus.a     = W'($urandom);
         bus.mode  = 2'($urandom);
         bus.amt   = 3'($urandom);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      check({tag, "_lat"}, lat, amt + 1);
      check({tag, "_busy_cycles"}, nbusy, amt);
      check({tag, "_y"}, bus.y, ey);
      check({tag, "_carry"}, bus.carry, ec);
      check({tag, "_zero"}, bus.zero, (ey == 0));
      check({tag, "_ready"}, bus.ready, 1);
      last_y = ey;
      last_c = ec;
   endtask

   initial begin
      bit         seen_done;
      logic [1:0] rm;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 2'd0;
      bus.amt   = '0;
      bus.a     = '0;
      last_y    = '0;
      last_c    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_y", bus.y, 0);
      check("rst_carry", bus.carry, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.ready, 1);
      check("rst_zero", bus.zero, 1);
      rst = 1'b0;

      op(2'd0, 8'hB5, 1, 0, "srl_b5");
      check("srl_b5_const", bus.y, 8'h5A);
      op(2'd1, 8'h81, 3, 0, "sll_81");
      check("sll_81_const", bus.y, 8'h08);
      op(2'd2, 8'h90, 4, 0, "sra_90");
      check("sra_90_const", bus.y, 8'hF9);
      op(2'd3, 8'h01, 1, 0, "ror_1");
      check("ror_1_const", bus.y, 8'h80);
      op(2'd3, 8'h01, 7, 0, "ror_7");
      check("ror_7_const", bus.y, 8'h02);
      op(2'd0, 8'h00, 0, 0, "amt0");
      op(2'd1, 8'hFF, 5, 0, "sll_ff");
      check("sll_ff_const", bus.y, 8'hE0);
      op(2'd0, 8'hE0, 4, 1, "b2b_srl");
      check("b2b_srl_const", bus.y, 8'h0E);
      op(2'd2, 8'h3C, 0, 1, "b2b_amt0");

      // Reset in the middle of an SRA run, with a start on the same edge.
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 2'd2; bus.a = 8'hC3; bus.amt = 3'd6;
      @(negedge clk);
      bus.start = 1'b0;
      seen_done = 1'b0;
      repeat (2) begin
         seen_done |= bus.done;
         @(negedge clk);
      end
      seen_done |= bus.done;
      rst = 1'b1;
      bus.start = 1'b1; bus.mode = 2'd0; bus.a = 8'h55; bus.amt = 3'd0;
      @(negedge clk);
      check("abort_no_done_before", seen_done, 0);
      check("abort_done", bus.done, 0);
      check("abort_y", bus.y, 0);
      check("abort_zero", bus.zero, 1);
      check("abort_ready", bus.ready, 1);
      check("abort_busy", bus.busy, 0);
      check("abort_carry", bus.carry, 0);
      rst = 1'b0;
      bus.start = 1'b0;
      last_y = '0;
      last_c = 1'b0;

      for (int i = 0; i < 150; i++) begin
         rm = 2'($urandom);
         op(rm, W'($urandom), $urandom_range(0, W - 1), bit'($urandom_range(0, 1)),
            $sformatf("rnd%0d", i));
      end
      op(2'd2, 8'h80, 7, 0, "sra_max");
      op(2'd1, 8'h01, 7, 1, "sll_max");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/desloca_seq.md
Name: desloca_seq

Overview:
- Parametrised, multi-cycle shift unit that generalises the fixed 8-bit logical right shifter.
- Supports four modes: logical right, logical left, arithmetic right and rotate right.
- Shift amount is programmable; the unit performs one bit position per clock under a start/ready/done handshake.
- Produces carry-out and zero flags for the ALU datapath, and replaces the combinational shift slot where area is tighter than latency.

Parameters:
- WIDTH, 8: data width in bits; must be a power of two and >= 2.
- SHW, $clog2(WIDTH): width of the shift-amount port (derived; not to be overridden).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only when ready=1.
- mode  in  2  00=SRL, 01=SLL, 10=SRA, 11=ROR; captured at start.
- amt  in  SHW  shift amount, 0..WIDTH-1; captured at start.
- a  in  WIDTH  operand; captured at start.
- ready  out  1  1 when a new start is accepted (state IDLE or DONE).
- busy  out  1  1 in state SHIFT.
- done  out  1  one-cycle pulse; result valid.
- y  out  WIDTH  result register.
- carry  out  1  last bit shifted or rotated out; 0 if amt=0.
- zero  out  1  1 when y==0; derived from the y register.

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - state=IDLE; y=0; carry=0; done=0; internal count=0.
  - busy=0, ready=1, zero=1.
  - rst overrides a start sampled on the same edge.
  - rst during SHIFT aborts the operation: no done pulse; outputs take reset values on the next cycle.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE/DONE with start=1 at an edge:
    - y<=a, mode and count<=amt captured, carry<=0.
    - Next state is DONE if amt==0, else SHIFT.
  - IDLE with start=0: stay in IDLE.
  - DONE with start=0: go to IDLE.
  - SHIFT at each edge:
    - y<=shift(y, mode) by one position, carry<=bit leaving y, count<=count-1.
    - Next state is DONE when count==1, else stay in SHIFT.
  - In SHIFT, start is ignored; mode/amt/a changes do not affect the operation in flight.
- Single-step shift rules:
  - SRL: y<={0, y[W-1:1]}, carry=y[0].
  - SLL: y<={y[W-2:0], 0}, carry=y[W-1].
  - SRA: y<={y[W-1], y[W-1:1]}, carry=y[0].
  - ROR: y<={y[0], y[W-1:1]}, carry=y[0].
- Outputs:
  - done = (state==DONE), registered.
  - Latency: done is high in cycle amt+1 after the start edge (amt=0 gives 1 cycle; amt=WIDTH-1 gives WIDTH cycles).
  - y, carry and zero hold their values after DONE until the next accepted start. Intermediate y values are visible during SHIFT and must not be consumed.
- Back-to-back operation: start high while in DONE is accepted. done drops the following cycle unless that new operation has amt=0, in which case done stays high one more cycle for the new result.
- y is never wider than WIDTH; there is no sign extension beyond WIDTH.

Test Plan:
- WIDTH=8, SRL, a=0xB5, amt=1 -> y=0x5A, carry=1, zero=0, done exactly 2 cycles after start edge, busy high 1 cycle.
- SLL a=0x81 amt=3 -> y=0x08, carry=0, done after 4 cycles; SRA a=0x90 amt=4 -> y=0xF9, carry=0.
- ROR a=0x01 amt=1 -> y=0x80, carry=1; ROR a=0x01 amt=7 -> y=0x02, carry=0, done after 8 cycles.
- amt=0, SRL a=0x00 -> y=0x00, carry=0, zero=1, done 1 cycle after start, busy never asserted.
- Start SLL a=0xFF amt=5, pulse start with a=0x12 at cycle 2 -> second start ignored, y=0xE0, carry=1. Immediately restart from DONE with SRL 0xE0 amt=4 -> y=0x0E.
- rst=1 at cycle 3 of an SRA amt=6 run -> no done pulse; next cycle y=0, zero=1, ready=1, state IDLE. A start on the same edge as rst is ignored.
